// File: rtl/body_cmd_receiver_pkg.sv
// Shared definitions for the body command link: frame layout, payload bit map,
// receiver FSM encoding and the command bundle with its reset / fail-safe values.
package body_cmd_receiver_pkg;

    localparam int unsigned FRAME_BITS = 19;
    localparam int unsigned DATA_BITS  = FRAME_BITS - 3;

    localparam int unsigned PosRight   = 0;
    localparam int unsigned PosLeft    = 1;
    localparam int unsigned PosBrake   = 2;
    localparam int unsigned PosDTime   = 3;
    localparam int unsigned PosLBeam   = 4;
    localparam int unsigned PosHBeam   = 5;
    localparam int unsigned PosPark    = 6;
    localparam int unsigned PosReverse = 7;
    localparam int unsigned PosDrive   = 8;
    localparam int unsigned PosRpmLsb  = 9;
    localparam int unsigned PosRsvLsb  = 13;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    typedef struct packed {
        logic       right;
        logic       left;
        logic       brake;
        logic       d_time;
        logic       l_beam;
        logic       h_beam;
        logic       park;
        logic       reverse;
        logic       drive;
        logic [3:0] rpm;
    } cmd_t;

    localparam cmd_t CmdReset = '{right: 1'b0, left: 1'b0, brake: 1'b0, d_time: 1'b0,
                                  l_beam: 1'b0, h_beam: 1'b0, park: 1'b1, reverse: 1'b0,
                                  drive: 1'b0, rpm: 4'd0};

    function automatic cmd_t decode_payload(input logic [15:0] p);
        cmd_t c;
        c.right   = p[PosRight];
        c.left    = p[PosLeft];
        c.brake   = p[PosBrake];
        c.d_time  = p[PosDTime];
        c.l_beam  = p[PosLBeam];
        c.h_beam  = p[PosHBeam];
        c.park    = p[PosPark];
        c.reverse = p[PosReverse];
        c.drive   = p[PosDrive];
        c.rpm     = p[PosRpmLsb +: 4];
        return c;
    endfunction

    function automatic logic frame_ok(input logic [15:0] p, input logic par);
        logic gear_multi;
        gear_multi = (p[PosPark] & p[PosReverse]) | (p[PosPark] & p[PosDrive]) |
                     (p[PosReverse] & p[PosDrive]);
        return (^{p, par} == 1'b0) && (p[PosRsvLsb +: 3] == 3'b000) && !gear_multi;
    endfunction

    // Link lost: stop blinking, light the car up, hold the gear.
    function automatic cmd_t fail_safe(input cmd_t c);
        cmd_t f;
        f        = c;
        f.right  = 1'b0;
        f.left   = 1'b0;
        f.brake  = 1'b1;
        f.l_beam = 1'b1;
        f.h_beam = 1'b0;
        f.d_time = 1'b0;
        f.rpm    = 4'd0;
        return f;
    endfunction

endpackage

// File: rtl/body_cmd_receiver_if.sv
// Serial line plus registered driver-command bus of the body command receiver.
interface body_cmd_receiver_if #(
    parameter int unsigned ERR_W = 8
);
    logic             sdata;
    logic             right;
    logic             left;
    logic             brake;
    logic             d_time;
    logic             l_beam;
    logic             h_beam;
    logic             park;
    logic             reverse;
    logic             drive;
    logic [3:0]       rpm;
    logic             frame_valid;
    logic             link_ok;
    logic [ERR_W-1:0] frame_err_cnt;

    modport master (
        output sdata,
        input  right, left, brake, d_time, l_beam, h_beam, park, reverse, drive, rpm,
        input  frame_valid, link_ok, frame_err_cnt
    );

    modport slave (
        input  sdata,
        output right, left, brake, d_time, l_beam, h_beam, park, reverse, drive, rpm,
        output frame_valid, link_ok, frame_err_cnt
    );
endinterface

// File: rtl/body_bit_sampler.sv
// Line front end: 2-FF synchroniser, falling-edge detect and the bit timer that
// strobes mid-bit samples while the receiver FSM is active.
module body_bit_sampler #(
    parameter int unsigned BIT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sdata_i,
    input  logic load_i,
    input  logic run_i,
    output logic fall_o,
    output logic strobe_o,
    output logic bit_o
);
    localparam int unsigned TW = $clog2(BIT_CYCLES);

    logic [2:0]    sync_q, sync_d;
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[1:0], sdata_i};
        cnt_d  = cnt_q;
        // First strobe lands half a bit after the edge, then one per bit period.
        if (load_i) begin
            cnt_d = TW'(BIT_CYCLES / 2 - 1);
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? TW'(BIT_CYCLES - 1) : cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 3'b111;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_o    = sync_q[1];
    assign fall_o   = sync_q[2] & ~sync_q[1];
    assign strobe_o = run_i & (cnt_q == '0);

endmodule

// File: rtl/body_cmd_receiver.sv
// Body command link receiver: frames 19-bit serial words, validates them and
// drives the registered command bus with link-loss fail-safe and error counting.
module body_cmd_receiver
    import body_cmd_receiver_pkg::*;
#(
    parameter int unsigned BIT_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned ERR_W          = 8
) (
    input  logic              CLK,
    input  logic              RST,
    body_cmd_receiver_if.slave bus
);
    localparam int unsigned     ToW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);

    rx_state_e        state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic             par_q, par_d;
    cmd_t             cmd_q, cmd_d;
    logic             fv_q, fv_d;
    logic             link_q, link_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ToW-1:0]   to_q, to_d;

    logic fall, strobe, bit_val, load, run;
    logic frame_done, accept, reject;
    cmd_t rx_cmd;

    assign run = (state_q != StIdle);

    body_bit_sampler #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_sampler (
        .clk_i   (CLK),
        .rst_i   (RST),
        .sdata_i (bus.sdata),
        .load_i  (load),
        .run_i   (run),
        .fall_o  (fall),
        .strobe_o(strobe),
        .bit_o   (bit_val)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        load       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    load    = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (strobe) begin
                    state_d   = bit_val ? StIdle : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (strobe) begin
                    shift_d = {bit_val, shift_q[15:1]};
                    if (bit_cnt_q == LastData) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (strobe) begin
                    par_d   = bit_val;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (strobe) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = frame_done & bit_val & frame_ok(shift_q, par_q);
    assign reject = frame_done & ~accept;

    always_comb begin
        cmd_d  = cmd_q;
        fv_d   = 1'b0;
        link_d = link_q;
        err_d  = err_q;
        to_d   = to_q;
        rx_cmd = decode_payload(shift_q);
        // A frame with no gear selected leaves the gear selector where it was.
        if (!(rx_cmd.park | rx_cmd.reverse | rx_cmd.drive)) begin
            rx_cmd.park    = cmd_q.park;
            rx_cmd.reverse = cmd_q.reverse;
            rx_cmd.drive   = cmd_q.drive;
        end
        if (accept) begin
            cmd_d  = rx_cmd;
            fv_d   = 1'b1;
            link_d = 1'b1;
            to_d   = '0;
        end else if (to_q == ToLast) begin
            cmd_d  = fail_safe(cmd_q);
            link_d = 1'b0;
        end else begin
            to_d = to_q + ToW'(1);
        end
        if (reject && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            cmd_q     <= CmdReset;
            fv_q      <= 1'b0;
            link_q    <= 1'b0;
            err_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            cmd_q     <= cmd_d;
            fv_q      <= fv_d;
            link_q    <= link_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    assign bus.right         = cmd_q.right;
    assign bus.left          = cmd_q.left;
    assign bus.brake         = cmd_q.brake;
    assign bus.d_time        = cmd_q.d_time;
    assign bus.l_beam        = cmd_q.l_beam;
    assign bus.h_beam        = cmd_q.h_beam;
    assign bus.park          = cmd_q.park;
    assign bus.reverse       = cmd_q.reverse;
    assign bus.drive         = cmd_q.drive;
    assign bus.rpm           = cmd_q.rpm;
    assign bus.frame_valid   = fv_q;
    assign bus.link_ok       = link_q;
    assign bus.frame_err_cnt = err_q;

endmodule

// File: tb/tb_body_cmd_receiver.sv
// Self-checking bench for body_cmd_receiver: table of frames with expected bus
// state, a frame_valid scoreboard, and hand sequences for glitch/timeout/reset/saturation.
module tb_body_cmd_receiver;
    localparam int unsigned BC = 4;
    localparam int unsigned TO = 1000;

    // {right,left,brake,d_time,l_beam,h_beam,park,reverse,drive,rpm}
    localparam logic [12:0] ExpReset = 13'b0_0_0_0_0_0_1_0_0_0000;
    localparam logic [12:0] ExpA     = 13'b1_0_0_1_0_0_0_0_1_0010;
    localparam logic [12:0] ExpB     = 13'b0_1_1_0_1_1_0_0_1_0000;
    localparam logic [12:0] ExpC     = 13'b0_0_0_0_0_0_0_1_0_1111;
    localparam logic [12:0] ExpD     = 13'b0_0_0_0_0_0_1_0_0_0000;
    localparam logic [12:0] ExpSafe  = 13'b0_0_1_0_1_0_0_0_1_0000;

    typedef struct {
        logic [15:0] payload;
        logic        par_flip;
        logic        stop;
        logic        ok;
        logic [12:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   fv_cyc = 0;
    int   exp_err = 0;
    logic [12:0] exp_q[$];
    logic [12:0] outs;
    vec_t vecs[12];

    body_cmd_receiver_if #(.ERR_W(8)) bus ();

    body_cmd_receiver #(
        .BIT_CYCLES    (BC),
        .TIMEOUT_CYCLES(TO),
        .ERR_W         (8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    assign outs = {bus.right, bus.left, bus.brake, bus.d_time, bus.l_beam, bus.h_beam,
                   bus.park, bus.reverse, bus.drive, bus.rpm};

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every frame_valid pulse must match the next queued expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.frame_valid) begin
            fv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame_valid: got pulse, expected none (cycle %0d)",
                         cyc);
            end else begin
                check("frame_outputs", 32'(outs), 32'(exp_q.pop_front()));
                check("frame_link_ok", 32'(bus.link_ok), 32'd1);
            end
        end
    end

    task automatic send_frame(input logic [15:0] p, input logic flip, input logic stop,
                              input int nbits);
        logic [18:0] f;
        f = {stop, (^p) ^ flip, p, 1'b0};
        for (int b = 0; b < nbits; b++) begin
            bus.sdata = f[b];
            repeat (BC) @(posedge clk);
            #1;
        end
        if (nbits == 19) begin
            bus.sdata = 1'b1;
            repeat (BC) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{16'h0509, 1'b0, 1'b1, 1'b1, ExpA};
        vecs[1]  = '{16'h0509, 1'b1, 1'b1, 1'b0, ExpA};
        vecs[2]  = '{16'h0140, 1'b0, 1'b1, 1'b0, ExpA};
        vecs[3]  = '{16'h0509, 1'b0, 1'b0, 1'b0, ExpA};
        vecs[4]  = '{16'h2000, 1'b0, 1'b1, 1'b0, ExpA};
        vecs[5]  = '{16'h0036, 1'b0, 1'b1, 1'b1, ExpB};
        vecs[6]  = '{16'h1E80, 1'b0, 1'b1, 1'b1, ExpC};
        vecs[7]  = '{16'h0040, 1'b0, 1'b1, 1'b1, ExpD};
        vecs[8]  = '{16'h0000, 1'b0, 1'b1, 1'b1, ExpD};
        vecs[9]  = '{16'hFFFF, 1'b0, 1'b1, 1'b0, ExpD};
        vecs[10] = '{16'h01C0, 1'b0, 1'b1, 1'b0, ExpD};
        vecs[11] = '{16'h0180, 1'b0, 1'b1, 1'b0, ExpD};

        bus.sdata = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'(outs), 32'(ExpReset));
        check("reset_link_ok", 32'(bus.link_ok), 32'd0);
        check("reset_err_cnt", 32'(bus.frame_err_cnt), 32'd0);
        check("reset_frame_valid", 32'(bus.frame_valid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].ok) exp_q.push_back(vecs[i].exp);
            else exp_err++;
            send_frame(vecs[i].payload, vecs[i].par_flip, vecs[i].stop, 19);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_outputs", i), 32'(outs), 32'(vecs[i].exp));
            check($sformatf("vec%0d_err_cnt", i), 32'(bus.frame_err_cnt), 32'(exp_err));
            check($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'd0);
        end

        // Low pulse of BIT_CYCLES/2-1 cycles is a glitch, not a frame.
        @(posedge clk);
        #1 bus.sdata = 1'b0;
        repeat (BC / 2 - 1) @(posedge clk);
        #1 bus.sdata = 1'b1;
        repeat (4 * BC) @(posedge clk);
        #1;
        check("glitch_err_cnt", 32'(bus.frame_err_cnt), 32'(exp_err));
        exp_q.push_back(ExpC);
        send_frame(16'h1E80, 1'b0, 1'b1, 19);
        repeat (2) @(negedge clk);
        check("after_glitch_outputs", 32'(outs), 32'(ExpC));

        // Timeout: link_ok is high for exactly TO cycles after the last accept.
        exp_q.push_back(ExpA);
        send_frame(16'h0509, 1'b0, 1'b1, 19);
        for (int g = 0; g < 3 * TO && cyc < fv_cyc + int'(TO) - 1; g++) @(negedge clk);
        check("timeout_pre_link_ok", 32'(bus.link_ok), 32'd1);
        check("timeout_pre_outputs", 32'(outs), 32'(ExpA));
        @(negedge clk);
        check("timeout_link_ok", 32'(bus.link_ok), 32'd0);
        check("timeout_outputs", 32'(outs), 32'(ExpSafe));
        exp_q.push_back(ExpA);
        send_frame(16'h0509, 1'b0, 1'b1, 19);
        repeat (2) @(negedge clk);
        check("restore_outputs", 32'(outs), 32'(ExpA));
        check("restore_link_ok", 32'(bus.link_ok), 32'd1);

        // Reset in the middle of data bit 7 discards the frame.
        send_frame(16'h0509, 1'b0, 1'b1, 8);
        bus.sdata = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.sdata = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_err = 0;
        check("midreset_outputs", 32'(outs), 32'(ExpReset));
        check("midreset_link_ok", 32'(bus.link_ok), 32'd0);
        check("midreset_err_cnt", 32'(bus.frame_err_cnt), 32'd0);
        exp_q.push_back(ExpA);
        send_frame(16'h0509, 1'b0, 1'b1, 19);
        repeat (2) @(negedge clk);
        check("post_reset_outputs", 32'(outs), 32'(ExpA));
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);

        // 300 rejects saturate the 8-bit error counter.
        for (int i = 0; i < 300; i++) begin
            send_frame(16'h0509, 1'b1, 1'b1, 19);
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            if (i == 9 || i == 253 || i == 254) begin
                @(negedge clk);
                check($sformatf("sat_err_cnt_%0d", i + 1), 32'(bus.frame_err_cnt),
                      32'(exp_err));
            end
        end
        repeat (2) @(negedge clk);
        check("sat_err_cnt_final", 32'(bus.frame_err_cnt), 32'd255);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
